// File: rtl/eth_ctrl_pkg.sv
// Shared types and defaults for the ctrl-domain uplink TX arbiter.
package eth_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } ctrl_state_t;

    localparam int LEN_W             = 16;
    localparam int DEF_MAX_PKT_WORDS = 256;
    localparam int DEF_FIFO_WORDS    = 2048;
    localparam int DEF_FIFO_PKTS     = 16;

    // Credit counters must be able to hold the full depth itself.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_words);
        return (len != '0) && (int'(len) <= max_words);
    endfunction

endpackage

// File: rtl/eth_ctrl_credit_cnt.sv
// Word and packet credit counters for the downstream FIFOs, with clamp and sticky overflow flag.
module eth_ctrl_credit_cnt
    import eth_ctrl_pkg::*;
#(
    parameter  int FIFO_WORDS = DEF_FIFO_WORDS,
    parameter  int FIFO_PKTS  = DEF_FIFO_PKTS,
    localparam int WCW        = credit_w(FIFO_WORDS),
    localparam int PCW        = credit_w(FIFO_PKTS)
) (
    input  logic             i_crtl_clk,
    input  logic             i_crtl_rst,
    input  logic             consume_en,
    input  logic [LEN_W-1:0] consume_words,
    input  logic             ret_valid,
    input  logic [LEN_W-1:0] ret_words,
    input  logic             refund_en,
    input  logic [LEN_W-1:0] refund_words,
    output logic [WCW-1:0]   word_credit,
    output logic [PCW-1:0]   pkt_credit,
    output logic             credit_err
);

    localparam int SUM_W = LEN_W + 2;

    logic [SUM_W-1:0] word_sum;
    logic [SUM_W-1:0] pkt_sum;
    logic             word_ovf;
    logic             pkt_ovf;

    // Consume never exceeds the current credit, so the sum cannot underflow.
    always_comb begin
        word_sum = SUM_W'(word_credit)
                 + (ret_valid  ? SUM_W'(ret_words)     : '0)
                 + (refund_en  ? SUM_W'(refund_words)  : '0)
                 - (consume_en ? SUM_W'(consume_words) : '0);
        pkt_sum  = SUM_W'(pkt_credit) + SUM_W'(ret_valid) - SUM_W'(consume_en);
        word_ovf = word_sum > SUM_W'(FIFO_WORDS);
        pkt_ovf  = pkt_sum  > SUM_W'(FIFO_PKTS);
    end

    always_ff @(posedge i_crtl_clk or posedge i_crtl_rst) begin
        if (i_crtl_rst) begin
            word_credit <= WCW'(FIFO_WORDS);
            pkt_credit  <= PCW'(FIFO_PKTS);
            credit_err  <= 1'b0;
        end else begin
            word_credit <= word_ovf ? WCW'(FIFO_WORDS) : word_sum[WCW-1:0];
            pkt_credit  <= pkt_ovf  ? PCW'(FIFO_PKTS)  : pkt_sum[PCW-1:0];
            credit_err  <= credit_err | word_ovf | pkt_ovf;
        end
    end

endmodule

// File: rtl/eth_ctrl_tx_arbiter.sv
// Round-robin packet arbiter feeding the uplink ctrl stream; grants only when downstream credits cover the packet.
//   state | meaning
//   IDLE  | no grant; waits for enable and any request
//   ARB   | picks next requester; grants when credits allow, drains on illegal length
//   XFER  | forwards grantee beats with one cycle latency, counts beats against length
//   DRAIN | accepts and discards grantee beats until its tlast
module eth_ctrl_tx_arbiter
    import eth_ctrl_pkg::*;
#(
    parameter  int NUM_SRC       = 4,
    parameter  int DATA_W        = 64,
    parameter  int MAX_PKT_WORDS = DEF_MAX_PKT_WORDS,
    parameter  int FIFO_WORDS    = DEF_FIFO_WORDS,
    parameter  int FIFO_PKTS     = DEF_FIFO_PKTS,
    localparam int KEEP_W        = DATA_W / 8,
    localparam int WCW           = credit_w(FIFO_WORDS),
    localparam int PCW           = credit_w(FIFO_PKTS)
) (
    input  logic                      i_crtl_clk,
    input  logic                      i_crtl_rst,
    input  logic                      i_enable,
    input  logic [NUM_SRC-1:0]        i_src_req,
    input  logic [NUM_SRC*LEN_W-1:0]  i_src_len,
    input  logic [NUM_SRC-1:0]        s_src_axis_tvalid,
    input  logic [NUM_SRC*DATA_W-1:0] s_src_axis_tdata,
    input  logic [NUM_SRC-1:0]        s_src_axis_tlast,
    input  logic [NUM_SRC*KEEP_W-1:0] s_src_axis_tkeep,
    input  logic [NUM_SRC-1:0]        s_src_axis_tuser,
    output logic [NUM_SRC-1:0]        s_src_axis_tready,
    output logic                      m_ctrl_axis_tvalid,
    output logic [DATA_W-1:0]         m_ctrl_axis_tdata,
    output logic                      m_ctrl_axis_tlast,
    output logic [KEEP_W-1:0]         m_ctrl_axis_tkeep,
    output logic                      m_ctrl_axis_tuser,
    input  logic                      i_ret_valid,
    input  logic [LEN_W-1:0]          i_ret_words,
    output logic [NUM_SRC-1:0]        o_grant,
    output logic                      o_busy,
    output logic                      o_len_err,
    output logic                      o_credit_err,
    output logic [WCW-1:0]            o_word_credit,
    output logic [PCW-1:0]            o_pkt_credit
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    ctrl_state_t        state, state_next;
    logic [IDX_W-1:0]   rr_ptr, rr_next, gidx, gidx_next, gidx_inc, pick, cand;
    logic               found;
    logic [LEN_W-1:0]   beat_cnt, beat_next, len_q, len_next, sel_len, beat_num;
    logic [NUM_SRC-1:0] grant_next;
    logic               credit_ok, src_valid, src_last;
    logic               consume_en, refund_en, len_err_next, m_valid_next, m_last_next;
    logic [LEN_W-1:0]   refund_words;

    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        cand  = rr_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!found && i_src_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign sel_len   = i_src_len[int'(pick)*LEN_W +: LEN_W];
    assign credit_ok = (32'(sel_len) <= 32'(o_word_credit)) && (o_pkt_credit != '0);
    assign src_valid = s_src_axis_tvalid[gidx];
    assign src_last  = s_src_axis_tlast[gidx];
    assign beat_num  = beat_cnt + LEN_W'(1);
    assign gidx_inc  = IDX_W'((int'(gidx) + 1) % NUM_SRC);

    always_comb begin
        state_next   = state;
        rr_next      = rr_ptr;
        gidx_next    = gidx;
        grant_next   = o_grant;
        beat_next    = beat_cnt;
        len_next     = len_q;
        consume_en   = 1'b0;
        refund_en    = 1'b0;
        refund_words = '0;
        len_err_next = 1'b0;
        m_valid_next = 1'b0;
        m_last_next  = 1'b0;
        case (state)
            IDLE: if (i_enable && |i_src_req) state_next = ARB;
            ARB: begin
                if (!i_enable || !found) begin
                    state_next = IDLE;
                end else if (!len_legal(sel_len, MAX_PKT_WORDS)) begin
                    len_err_next = 1'b1;
                    gidx_next    = pick;
                    grant_next   = NUM_SRC'(1) << pick;
                    state_next   = DRAIN;
                end else if (credit_ok) begin
                    consume_en   = 1'b1;
                    gidx_next    = pick;
                    grant_next   = NUM_SRC'(1) << pick;
                    len_next     = sel_len;
                    beat_next    = '0;
                    state_next   = XFER;
                end
                // Insufficient credit: hold the pointer so a large packet is not starved.
            end
            XFER: if (src_valid) begin
                beat_next    = beat_num;
                m_valid_next = 1'b1;
                if (src_last) begin
                    m_last_next  = 1'b1;
                    refund_en    = beat_num < len_q;
                    refund_words = len_q - beat_num;
                    grant_next   = '0;
                    rr_next      = gidx_inc;
                    state_next   = IDLE;
                end else if (beat_num == len_q) begin
                    m_last_next  = 1'b1;
                    len_err_next = 1'b1;
                    state_next   = DRAIN;
                end
            end
            DRAIN: if (src_valid && src_last) begin
                grant_next = '0;
                rr_next    = gidx_inc;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_crtl_clk or posedge i_crtl_rst) begin
        if (i_crtl_rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gidx     <= '0;
            beat_cnt <= '0;
            len_q    <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_next;
            gidx     <= gidx_next;
            beat_cnt <= beat_next;
            len_q    <= len_next;
        end
    end

    always_ff @(posedge i_crtl_clk or posedge i_crtl_rst) begin
        if (i_crtl_rst) begin
            m_ctrl_axis_tvalid <= 1'b0;
            m_ctrl_axis_tlast  <= 1'b0;
            m_ctrl_axis_tdata  <= '0;
            m_ctrl_axis_tkeep  <= '0;
            m_ctrl_axis_tuser  <= 1'b0;
            o_grant            <= '0;
            o_len_err          <= 1'b0;
        end else begin
            m_ctrl_axis_tvalid <= m_valid_next;
            m_ctrl_axis_tlast  <= m_last_next;
            if (m_valid_next) begin
                m_ctrl_axis_tdata <= s_src_axis_tdata[int'(gidx)*DATA_W +: DATA_W];
                m_ctrl_axis_tkeep <= s_src_axis_tkeep[int'(gidx)*KEEP_W +: KEEP_W];
                m_ctrl_axis_tuser <= s_src_axis_tuser[gidx];
            end
            o_grant   <= grant_next;
            o_len_err <= len_err_next;
        end
    end

    assign s_src_axis_tready = (state == XFER || state == DRAIN) ? o_grant : '0;
    assign o_busy            = state != IDLE;

    eth_ctrl_credit_cnt #(
        .FIFO_WORDS (FIFO_WORDS),
        .FIFO_PKTS  (FIFO_PKTS)
    ) u_credit (
        .i_crtl_clk    (i_crtl_clk),
        .i_crtl_rst    (i_crtl_rst),
        .consume_en    (consume_en),
        .consume_words (sel_len),
        .ret_valid     (i_ret_valid),
        .ret_words     (i_ret_words),
        .refund_en     (refund_en),
        .refund_words  (refund_words),
        .word_credit   (o_word_credit),
        .pkt_credit    (o_pkt_credit),
        .credit_err    (o_credit_err)
    );

endmodule

// File: tb/tb_eth_ctrl_tx_arbiter.sv
// Bench for eth_ctrl_tx_arbiter: vector table plus hand sequences, output beats checked through a scoreboard queue.
module tb_eth_ctrl_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [3:0]   src_req;
    logic [63:0]  src_len;
    logic [3:0]   tvalid, tlast, tuser, tready;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic         m_tvalid, m_tlast, m_tuser;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tkeep;
    logic         ret_valid;
    logic [15:0]  ret_words;
    logic [3:0]   grant;
    logic         busy, len_err, credit_err;
    logic [11:0]  word_credit;
    logic [4:0]   pkt_credit;

    eth_ctrl_tx_arbiter dut (
        .i_crtl_clk(clk), .i_crtl_rst(rst), .i_enable(en),
        .i_src_req(src_req), .i_src_len(src_len),
        .s_src_axis_tvalid(tvalid), .s_src_axis_tdata(tdata), .s_src_axis_tlast(tlast),
        .s_src_axis_tkeep(tkeep), .s_src_axis_tuser(tuser), .s_src_axis_tready(tready),
        .m_ctrl_axis_tvalid(m_tvalid), .m_ctrl_axis_tdata(m_tdata), .m_ctrl_axis_tlast(m_tlast),
        .m_ctrl_axis_tkeep(m_tkeep), .m_ctrl_axis_tuser(m_tuser),
        .i_ret_valid(ret_valid), .i_ret_words(ret_words),
        .o_grant(grant), .o_busy(busy), .o_len_err(len_err), .o_credit_err(credit_err),
        .o_word_credit(word_credit), .o_pkt_credit(pkt_credit)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [7:0]  keep;
        logic        user;
    } beat_t;

    typedef struct {
        int src; int len; int beats; bit gap;
        int exp_word; int exp_pkt; int exp_lerr;
    } vec_t;

    beat_t exp_q[$];
    int    grant_log[$];
    vec_t  vecs[9];

    int tests = 0, fails = 0, cyc = 0;
    int lerr_cnt, m_beats, ret_mode, ret_w;
    bit ret_pulse;
    logic [3:0] prev_grant;

    bit [3:0] p_act, p_gnt, p_gap;
    int p_len[4], p_beats[4], p_sent[4], p_seq[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_data(input int s, input int n, input int seq);
        return {s[7:0], seq[23:0], n[31:0]};
    endfunction

    task automatic step();
        beat_t e;
        @(negedge clk);
        cyc++;
        if (m_tvalid) begin
            m_beats++;
            if (exp_q.size() == 0) chk("m_unexpected_beat", 64'(m_tvalid), 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("m_tdata", m_tdata, e.data);
                chk("m_last_keep_user", 64'({m_tlast, m_tkeep, m_tuser}), 64'({e.last, e.keep, e.user}));
            end
        end
        if (len_err) lerr_cnt++;
        if (grant != 4'd0 && prev_grant == 4'd0)
            for (int s = 0; s < 4; s++) if (grant[s]) grant_log.push_back(s);
        prev_grant = grant;
        ret_valid = 1'b0;
        if (ret_pulse) begin ret_valid = 1'b1; ret_words = 16'(ret_w); ret_pulse = 1'b0; end
        if (ret_mode == 1 && busy && grant == 4'd0) begin
            ret_valid = 1'b1; ret_words = 16'(ret_w); ret_mode = 0;
        end
        for (int s = 0; s < 4; s++) begin
            int  n = p_sent[s] + 1;
            bit  v;
            bit  lst;
            if (p_act[s]) begin
                if (grant[s]) p_gnt[s] = 1'b1;
                src_req[s] = !p_gnt[s];
                src_len[s*16 +: 16] = 16'(p_len[s]);
                v   = p_gnt[s] && (!p_gap[s] || cyc[0]);
                lst = (n == p_beats[s]);
                tvalid[s] = v;
                tdata[s*64 +: 64] = mk_data(s, n, p_seq[s]);
                tlast[s] = lst;
                tkeep[s*8 +: 8] = lst ? 8'h0F : 8'hFF;
                tuser[s] = n[0];
                if (v && tready[s]) begin
                    if (p_len[s] >= 1 && p_len[s] <= 256 && n <= p_len[s])
                        exp_q.push_back('{mk_data(s, n, p_seq[s]), lst || (n == p_len[s]),
                                          lst ? 8'h0F : 8'hFF, n[0]});
                    if (s == 0 && ret_mode == 2 && lst) begin
                        ret_valid = 1'b1; ret_words = 16'(ret_w); ret_mode = 0;
                    end
                    p_sent[s] = n;
                    if (lst) p_act[s] = 1'b0;
                end
            end else begin
                src_req[s] = 1'b0;
                tvalid[s]  = 1'b0;
                tlast[s]   = 1'b0;
            end
        end
    endtask

    task automatic start_pkt(input int s, input int len, input int beats, input bit gap);
        p_act[s] = 1'b1; p_gnt[s] = 1'b0; p_gap[s] = gap;
        p_len[s] = len; p_beats[s] = beats; p_sent[s] = 0; p_seq[s]++;
    endtask

    task automatic run_until_idle(input int budget);
        int c = 0;
        bit done;
        do begin
            step();
            c++;
            done = (p_act == 4'd0) && !busy && (exp_q.size() == 0);
        end while (!done && c < budget);
        chk("idle_within_budget", 64'(done), 64'd1);
        repeat (2) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b1; src_req = '0; src_len = '0; tvalid = '0; tlast = '0; tuser = '0;
        tdata = '0; tkeep = '0; ret_valid = 1'b0; ret_words = '0;
        p_act = '0; p_gnt = '0; exp_q.delete(); grant_log.delete();
        ret_mode = 0; ret_pulse = 1'b0; ret_w = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_grant = '0; lerr_cnt = 0; m_beats = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int exp_beats;
        //           src len  beats gap word  pkt lerr
        vecs[0] = '{0, 4,   4,   0, 2044, 15, 0};
        vecs[1] = '{1, 3,   2,   0, 2046, 15, 0};
        vecs[2] = '{2, 2,   5,   0, 2046, 15, 1};
        vecs[3] = '{3, 0,   3,   0, 2048, 16, 1};
        vecs[4] = '{1, 300, 2,   0, 2048, 16, 1};
        vecs[5] = '{2, 256, 256, 0, 1792, 15, 0};
        vecs[6] = '{3, 5,   5,   1, 2043, 15, 0};
        vecs[7] = '{0, 1,   1,   0, 2047, 15, 0};
        vecs[8] = '{0, 257, 1,   0, 2048, 16, 1};
        for (int s = 0; s < 4; s++) p_seq[s] = 0;

        do_reset();
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_credit_err", 64'(credit_err), 64'd0);
        chk("rst_tready", 64'(tready), 64'd0);
        chk("rst_word_credit", 64'(word_credit), 64'd2048);
        chk("rst_pkt_credit", 64'(pkt_credit), 64'd16);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            start_pkt(vecs[i].src, vecs[i].len, vecs[i].beats, vecs[i].gap);
            run_until_idle(600);
            exp_beats = (vecs[i].len >= 1 && vecs[i].len <= 256)
                      ? ((vecs[i].beats < vecs[i].len) ? vecs[i].beats : vecs[i].len) : 0;
            chk($sformatf("vec%0d_word_credit", i), 64'(word_credit), 64'(vecs[i].exp_word));
            chk($sformatf("vec%0d_pkt_credit", i), 64'(pkt_credit), 64'(vecs[i].exp_pkt));
            chk($sformatf("vec%0d_len_err", i), 64'(lerr_cnt), 64'(vecs[i].exp_lerr));
            chk($sformatf("vec%0d_m_beats", i), 64'(m_beats), 64'(exp_beats));
        end

        // Early tlast refund: credit dips by len then gets the unused word back.
        do_reset();
        start_pkt(1, 3, 2, 0);
        c = 0;
        while (!p_gnt[1] && c < 20) begin step(); c++; end
        chk("refund_after_grant", 64'(word_credit), 64'd2045);
        run_until_idle(100);
        chk("refund_after_tlast", 64'(word_credit), 64'd2046);

        // Round robin from reset pointer.
        do_reset();
        for (int s = 0; s < 4; s++) start_pkt(s, 2, 2, 0);
        run_until_idle(200);
        chk("rr_grant_count", 64'(grant_log.size()), 64'd4);
        for (int s = 0; s < 4 && s < grant_log.size(); s++)
            chk($sformatf("rr_grant_%0d", s), 64'(grant_log[s]), 64'(s));
        chk("rr_m_beats", 64'(m_beats), 64'd8);
        chk("rr_word_credit", 64'(word_credit), 64'd2040);

        // Packet credit exhaustion: the 17th waits until one packet is returned.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            start_pkt(0, 1, 1, 0);
            run_until_idle(50);
        end
        chk("exhaust_pkt_credit", 64'(pkt_credit), 64'd0);
        start_pkt(0, 1, 1, 0);
        repeat (20) step();
        chk("pkt17_not_granted", 64'(p_gnt[0]), 64'd0);
        chk("pkt17_busy_in_arb", 64'(busy), 64'd1);
        ret_w = 1; ret_pulse = 1'b1;
        run_until_idle(50);
        chk("pkt17_sent", 64'(m_beats), 64'd17);
        chk("pkt17_word_credit", 64'(word_credit), 64'd2032);
        chk("pkt17_pkt_credit", 64'(pkt_credit), 64'd0);

        // Coincident terms: consume with a return, then refund with a return.
        do_reset();
        ret_w = 6; ret_mode = 1;
        start_pkt(0, 10, 10, 0);
        run_until_idle(100);
        chk("coinc_consume_ret_word", 64'(word_credit), 64'd2044);
        chk("coinc_consume_ret_pkt", 64'(pkt_credit), 64'd16);
        ret_w = 6; ret_mode = 2;
        start_pkt(0, 10, 8, 0);
        run_until_idle(100);
        chk("coinc_refund_ret_word", 64'(word_credit), 64'd2042);
        chk("coinc_refund_ret_pkt", 64'(pkt_credit), 64'd16);
        chk("coinc_no_credit_err", 64'(credit_err), 64'd0);

        // Return at full credit clamps and sets the sticky error.
        do_reset();
        ret_w = 1; ret_pulse = 1'b1;
        repeat (4) step();
        chk("clamp_word_credit", 64'(word_credit), 64'd2048);
        chk("clamp_pkt_credit", 64'(pkt_credit), 64'd16);
        chk("clamp_credit_err", 64'(credit_err), 64'd1);

        // Enable low blocks grants; dropping it mid-packet lets the packet finish.
        do_reset();
        en = 1'b0;
        start_pkt(0, 3, 3, 0);
        repeat (10) step();
        chk("disabled_busy", 64'(busy), 64'd0);
        chk("disabled_grant", 64'(grant), 64'd0);
        en = 1'b1;
        c = 0;
        while (!p_gnt[0] && c < 20) begin step(); c++; end
        en = 1'b0;
        run_until_idle(50);
        chk("enable_drop_beats", 64'(m_beats), 64'd3);

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        start_pkt(0, 8, 8, 0);
        c = 0;
        while (!m_tvalid && c < 20) begin step(); c++; end
        chk("midrst_in_xfer", 64'(m_tvalid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_grant", 64'(grant), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_tready", 64'(tready), 64'd0);
        chk("midrst_word_credit", 64'(word_credit), 64'd2048);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
